// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared shift-add multiplier.
// Provides a zero-operand shortcut, a bounded wait with timeout abort, and a single-cycle response strobe.
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req0_ready,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [2*WIDTH-1:0] rsp_product,
    output logic               rsp_error,
    output logic               mul_go,
    output logic [WIDTH-1:0]   mul_multiplicand,
    output logic [WIDTH-1:0]   mul_multiplier,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               busy
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               err_q, err_d;
    logic               sel;
    logic               accept;
    logic [WIDTH-1:0]   sel_a, sel_b;

    // On a tie the requester that did not win last time is selected.
    assign sel        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !sel;
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;
    assign sel_a      = sel ? req1_a : req0_a;
    assign sel_b      = sel ? req1_b : req0_b;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        prod_d       = prod_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d      = sel;
                    last_grant_d = sel;
                    cnt_d        = '0;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    if (sel_a == '0 || sel_b == '0) begin
                        prod_d  = '0;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // Completion wins over a timeout landing in the same cycle.
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            prod_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            prod_q       <= prod_d;
            err_q        <= err_d;
        end
    end

    assign mul_go           = (state_q == ISSUE);
    assign busy             = (state_q != IDLE);
    assign rsp0_valid       = (state_q == RESP) && !owner_q;
    assign rsp1_valid       = (state_q == RESP) && owner_q;
    assign rsp_product      = prod_q;
    assign rsp_error        = err_q;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: requesters and a behavioural multiplier drive the DUT.
// A monitor predicts grants and results from the arbitration rules and checks every response.
module tb_mul_arbiter;
    localparam int W = 32;
    localparam int T = 63;

    logic          clk = 1'b0;
    logic          rst;
    logic          rv[2];
    logic [W-1:0]  ra[2], rb[2];
    int            rdel[2];
    logic          r0, r1, s0, s1, rsp_error, mul_go, mul_done, busy;
    logic [2*W-1:0] rsp_product, mul_product;
    logic [W-1:0]  mcand, mplier;

    mul_arbiter #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(rv[0]), .req1_valid(rv[1]),
        .req0_a(ra[0]), .req0_b(rb[0]), .req1_a(ra[1]), .req1_b(rb[1]),
        .req0_ready(r0), .req1_ready(r1),
        .rsp0_valid(s0), .rsp1_valid(s1),
        .rsp_product(rsp_product), .rsp_error(rsp_error),
        .mul_go(mul_go), .mul_multiplicand(mcand), .mul_multiplier(mplier),
        .mul_product(mul_product), .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [63:0] prod;
        logic        err;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    exp_t expq[$];
    int   dq[$];
    int   glog[$];
    int   n_cmp = 0, n_err = 0;
    int   cyc = 0, go_cnt = 0, go_exp = 0;
    int   lg = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard/monitor: predict on accept, compare on response strobe.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", {62'b0, r1, r0}, 64'd0);
            expq.delete();
            dq.delete();
            lg = 1;
        end else begin
            if (r0 && r1) chk("both_ready", 64'd1, 64'd0);
            if ((rv[0] && r0) || (rv[1] && r1)) begin
                exp_t e;
                int   own, eo;
                own = r1 ? 1 : 0;
                eo  = (rv[0] && rv[1]) ? 1 - lg : (rv[1] ? 1 : 0);
                chk("grant_owner", 64'(own), 64'(eo));
                lg = own;
                glog.push_back(own);
                e.owner   = own;
                e.acc_cyc = cyc;
                e.zero    = (ra[own] == 0) || (rb[own] == 0);
                if (e.zero) begin
                    e.prod = 64'd0;
                    e.err  = 1'b0;
                end else begin
                    go_exp++;
                    dq.push_back(rdel[own]);
                    // Done lands in WAIT cycle d-1; the last legal WAIT cycle is number T.
                    if (rdel[own] != 0 && rdel[own] <= T + 1) begin
                        e.prod = {32'd0, ra[own]} * {32'd0, rb[own]};
                        e.err  = 1'b0;
                    end else begin
                        e.prod = 64'd0;
                        e.err  = 1'b1;
                    end
                end
                expq.push_back(e);
            end
            if (s0 || s1) begin
                if (s0 && s1) chk("both_rsp_valid", 64'd1, 64'd0);
                if (expq.size() == 0) begin
                    chk("unexpected_rsp", {62'b0, s1, s0}, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("rsp_owner", 64'(s1 ? 1 : 0), 64'(e.owner));
                    chk("rsp_product", rsp_product, e.prod);
                    chk("rsp_error", 64'(rsp_error), 64'(e.err));
                    if (e.zero) chk("zero_latency", 64'(cyc - e.acc_cyc), 64'd1);
                end
            end
            if (mul_go) go_cnt++;
        end
    end

    // Behavioural shared multiplier: answers d cycles after go, or never when d==0.
    initial begin
        mul_done    = 1'b0;
        mul_product = 64'd0;
        forever begin
            @(negedge clk);
            if (mul_go && !rst) begin
                int          d;
                logic [63:0] p;
                d = (dq.size() != 0) ? dq.pop_front() : 0;
                p = {32'd0, mcand} * {32'd0, mplier};
                if (d > 0) begin
                    repeat (d) @(posedge clk);
                    #1 mul_done = 1'b1;
                    mul_product = p;
                    @(posedge clk);
                    #1 mul_done = 1'b0;
                    mul_product = {$urandom, $urandom};
                end
            end
        end
    end

    task automatic req(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input int d);
        int k;
        @(posedge clk);
        #1;
        rv[n] = 1'b1; ra[n] = a; rb[n] = b; rdel[n] = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(n == 0 ? r0 : r1) && k < 5000);
        if (k >= 5000) chk("req_wait_timeout", 64'(k), 64'd0);
        @(posedge clk);
        #1 rv[n] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expq.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 3000) chk("drain_timeout", 64'(expq.size()), 64'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic rand_req(input int n, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [W-1:0] a, b;
            int m, r, d;
            m = $urandom_range(0, 9);
            a = $urandom; b = $urandom;
            if (m == 0) a = 0;
            else if (m == 1) b = 0;
            else if (m == 2) begin a = '1; b = '1; end
            if (a == 0 && m > 1) a = 1;
            if (b == 0 && m > 1) b = 1;
            r = $urandom_range(0, 19);
            d = (r == 0) ? 0 : (r == 1) ? T + 1 : (r == 2) ? T + 2 : $urandom_range(1, 20);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            req(n, a, b, d);
        end
    endtask

    initial begin
        int g0;
        rv[0] = 0; rv[1] = 0; ra[0] = 0; ra[1] = 0; rb[0] = 0; rb[1] = 0;
        rdel[0] = 0; rdel[1] = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {56'd0, s0, s1, rsp_error, mul_go, busy, r0, r1, 1'b0}, 64'd0);
        chk("reset_product", rsp_product, 64'd0);
        chk("reset_operands", {mcand, mplier}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single request, done 33 cycles after go.
        g0 = go_cnt;
        req(0, 3, 5, 33);
        drain();
        chk("single_go_pulses", 64'(go_cnt - g0), 64'd1);
        chk("single_product", rsp_product, 64'd15);

        // Ties after reset alternate starting with requester 0.
        do_reset();
        glog.delete();
        fork
            begin req(0, 7, 9, 3); req(0, 11, 13, 4); end
            begin req(1, 2, 6, 5); req(1, 4, 8, 2); end
        join
        drain();
        chk("tie_grant_count", 64'(glog.size()), 64'd4);
        if (glog.size() == 4)
            chk("tie_grant_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0]},
                64'h00_01_00_01);

        // Zero shortcut never starts the multiplier.
        g0 = go_cnt;
        req(1, 0, 32'hFFFF_FFFF, 7);
        drain();
        chk("zero_no_go", 64'(go_cnt - g0), 64'd0);

        // Timeout boundaries: never done, done at counter==T, done one cycle too late.
        req(0, 5, 6, 0);
        drain();
        chk("timeout_error", 64'(rsp_error), 64'd1);
        req(0, 5, 6, T + 1);
        drain();
        chk("done_at_limit_error", 64'(rsp_error), 64'd0);
        req(0, 5, 6, T + 2);
        drain();
        chk("late_done_error", 64'(rsp_error), 64'd1);

        // Abort from WAIT; the late done must not produce a response.
        req(0, 9, 9, 30);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; rv[1] = 1'b1; ra[1] = 3; rb[1] = 3;
        @(posedge clk);
        #1 rst = 1'b0; rv[1] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        req(0, 4, 5, 3);
        drain();
        chk("after_abort_product", rsp_product, 64'd20);

        // Maximum operands.
        req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        drain();
        chk("max_product", rsp_product, 64'hFFFF_FFFE_0000_0001);

        fork
            rand_req(0, 60);
            rand_req(1, 60);
        join
        drain();
        chk("go_count", 64'(go_cnt), 64'(go_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
